// File: rtl/led_pkg.sv
// Shared constants for the LED blinker input front end: debounce defaults,
// system clock rate and the reset values of the conditioned outputs.
package led_pkg;

    localparam int   DEBOUNCE_CYCLES_DEFAULT = 250;   // 10 ms at CLK_HZ
    localparam int   CLK_HZ                  = 25000;

    localparam logic SWITCH_RST      = 1'b0;
    localparam logic ENABLE_RST      = 1'b0;
    localparam logic SEL_CHANGED_RST = 1'b0;

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: 2-flop synchroniser followed by a counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_channel
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic clean
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchroniser into a single stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= SWITCH_RST;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample matching the accepted level restarts the count, so a
            // short glitch never reaches the accepted level.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clean = stable;

endmodule

// File: rtl/led_input_conditioner.sv
// Board-pin front end for the LED blinker: debounced rate switches, enable
// button and a rate-change pulse. Define LED_ENABLE_TOGGLE_EN for toggle enable.
module led_input_conditioner
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sw1_raw,
    input  logic sw2_raw,
    input  logic btn_raw,
    output logic switch1,
    output logic switch2,
    output logic enable,
    output logic sel_changed
);

    logic       stable_btn;
    logic [1:0] sel_prev;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (sw1_raw),
        .clean   (switch1)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (sw2_raw),
        .clean   (switch2)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_raw),
        .clean   (stable_btn)
    );

    // Comparing the pair as one vector gives a single pulse when both move together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_prev    <= {SWITCH_RST, SWITCH_RST};
            sel_changed <= SEL_CHANGED_RST;
        end else begin
            sel_prev    <= {switch1, switch2};
            sel_changed <= ({switch1, switch2} != sel_prev);
        end
    end

`ifdef LED_ENABLE_TOGGLE_EN
    logic stable_btn_d;
    logic btn_press;

    assign btn_press = stable_btn & ~stable_btn_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_btn_d <= 1'b0;
            enable       <= ENABLE_RST;
        end else begin
            stable_btn_d <= stable_btn;
            if (btn_press) begin
                enable <= ~enable;
            end
        end
    end
`else
    // Level mode: one register keeps the latency equal to the toggle build.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable <= ENABLE_RST;
        end else begin
            enable <= stable_btn;
        end
    end
`endif

endmodule

// File: tb/tb_led_input_conditioner.sv
// Self-checking bench for led_input_conditioner with DEBOUNCE_CYCLES=4:
// directed scenarios plus random switch/button activity against a window model.
module tb_led_input_conditioner;
    import led_pkg::*;

    localparam int D = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic sw1_raw = 1'b0;
    logic sw2_raw = 1'b0;
    logic btn_raw = 1'b0;
    logic switch1;
    logic switch2;
    logic enable;
    logic sel_changed;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    led_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sw1_raw     (sw1_raw),
        .sw2_raw     (sw2_raw),
        .btn_raw     (btn_raw),
        .switch1     (switch1),
        .switch2     (switch2),
        .enable      (enable),
        .sel_changed (sel_changed)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a channel's accepted level flips once the last D
    // values seen by the debouncer (raw delayed two edges, zeros after reset)
    // all disagree with it.
    bit hist [3][$];
    bit m_st   [3];
    bit m_prev [3];
    bit m_en;
    bit m_sel;

    function automatic void model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            hist[ch].delete();
            hist[ch].push_back(1'b0);
            hist[ch].push_back(1'b0);
            m_st[ch]   = 1'b0;
            m_prev[ch] = 1'b0;
        end
        m_en  = 1'b0;
        m_sel = 1'b0;
    endfunction

    function automatic void model_edge(input bit r1, input bit r2, input bit rb);
        bit old [3];
        bit raw [3];
        int idx;
        bit flip;
        old    = m_st;
        raw[0] = r1;
        raw[1] = r2;
        raw[2] = rb;
        m_sel  = ({old[0], old[1]} != {m_prev[0], m_prev[1]});
`ifdef LED_ENABLE_TOGGLE_EN
        m_en   = m_en ^ (old[2] & ~m_prev[2]);
`else
        m_en   = old[2];
`endif
        for (int ch = 0; ch < 3; ch++) begin
            hist[ch].push_back(raw[ch]);
            idx  = hist[ch].size() - 3;
            flip = (idx - D + 1 >= 0);
            for (int j = idx - D + 1; j <= idx && j >= 0; j++) begin
                if (hist[ch][j] == m_st[ch]) flip = 1'b0;
            end
            if (flip) m_st[ch] = ~m_st[ch];
            if (hist[ch].size() > D + 6) void'(hist[ch].pop_front());
        end
        m_prev = old;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".switch1"},     switch1,     m_st[0]);
        check({tag, ".switch2"},     switch2,     m_st[1]);
        check({tag, ".enable"},      enable,      m_en);
        check({tag, ".sel_changed"}, sel_changed, m_sel);
    endtask

    // One rising edge: update the model with the levels the DUT sampled,
    // then compare 1 time unit later, away from the edge.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge(sw1_raw, sw2_raw, btn_raw);
        #1;
        check_model(tag);
    endtask

    task automatic settle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check("rst.switch1", switch1, 1'b0);
        check("rst.switch2", switch2, 1'b0);
        check("rst.enable", enable, 1'b0);
        check("rst.sel_changed", sel_changed, 1'b0);
        #9 reset_n = 1'b1;

        // Idle inputs: nothing moves.
        for (int e = 1; e <= 10; e++) begin
            step("idle");
            check("idle.no_sel", sel_changed, 1'b0);
        end

        // sw1 held high: switch1 at edge 6, sel_changed at edge 7 only.
        sw1_raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step("sw1_rise");
            check("sw1_rise.edge_switch1", switch1, logic'(e >= 6));
            check("sw1_rise.edge_sel", sel_changed, logic'(e == 7));
        end

        // Glitches of 3 cycles on sw2 never get through.
        for (int p = 0; p < 5; p++) begin
            sw2_raw = 1'b1;
            for (int e = 0; e < 6; e++) begin
                if (e == 3) sw2_raw = 1'b0;
                step("glitch");
                check("glitch.switch2", switch2, 1'b0);
                check("glitch.no_sel", sel_changed, 1'b0);
            end
        end
        settle("glitch_tail", 6);

        // Both switches rise together: one sel_changed pulse.
        sw1_raw = 1'b0;
        settle("sw1_fall", 12);
        sw1_raw = 1'b1;
        sw2_raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step("both_rise");
            check("both_rise.edge_switch1", switch1, logic'(e >= 6));
            check("both_rise.edge_switch2", switch2, logic'(e >= 6));
            check("both_rise.edge_sel", sel_changed, logic'(e == 7));
        end

        // Button: press 10, release 10, press 10.
        btn_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step("btn_press1");
            check("btn_press1.edge_enable", enable, logic'(e >= 7));
        end
        btn_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step("btn_release");
`ifdef LED_ENABLE_TOGGLE_EN
            check("btn_release.edge_enable", enable, 1'b1);
`else
            check("btn_release.edge_enable", enable, logic'(e < 7));
`endif
        end
        btn_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step("btn_press2");
`ifdef LED_ENABLE_TOGGLE_EN
            check("btn_press2.edge_enable", enable, logic'(e < 7));
`else
            check("btn_press2.edge_enable", enable, logic'(e >= 7));
`endif
        end
        btn_raw = 1'b0;
        settle("btn_tail", 10);

        // Reset mid-debounce: switch2 is settled high, sw1 is counting (cnt=2).
        sw1_raw = 1'b0;
        settle("pre_rst", 12);
        sw1_raw = 1'b1;
        settle("mid_count", 4);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.switch1", switch1, 1'b0);
        check("async_rst.switch2", switch2, 1'b0);
        check("async_rst.enable", enable, 1'b0);
        check("async_rst.sel_changed", sel_changed, 1'b0);
        #2 reset_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step("post_rst");
            check("post_rst.edge_switch1", switch1, logic'(e >= 6));
            check("post_rst.edge_switch2", switch2, logic'(e >= 6));
        end

        // Random activity: mixes glitches and real changes of all lengths.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) sw1_raw = ~sw1_raw;
            if ($urandom_range(5) == 0) sw2_raw = ~sw2_raw;
            if ($urandom_range(7) == 0) btn_raw = ~btn_raw;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
